axil_reg_write: RTL and testbench

Parametrised AXI4-Lite write-channel slave for the capture IP register banks. Accepts AW and W independently, decodes into a bank of NUM_REGS control registers with byte-strobe merging, returns SLVERR on unmapped addresses and produces per-register write strobes plus self-clearing command bits (start-type bits) on register 0. It sits between the AXI interconnect and the capture/DMA control logic, alongside the existing read-channel slave.

---
 rtl/axil_reg_write.sv | 150 +++++++++++++++
 tb/tb_axil_reg_write.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_write.sv
// AXI4-Lite write slave: one-entry AW/W slots commit into a strobed register bank one edge after both are held.
// Ready drops while a slot is full; a held response blocks the next commit until BREADY.
module axil_reg_write #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 8,
    parameter int                NUM_REGS   = 4,
    parameter logic [DATA_W-1:0] PULSE_MASK = 'h1
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic [31:0]                AWADDR,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [DATA_W-1:0]          WDATA,
    input  logic [DATA_W/8-1:0]        WSTRB,
    input  logic                       WVALID,
    output logic                       WREADY,
    output logic [1:0]                 BRESP,
    output logic                       BVALID,
    input  logic                       BREADY,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic [NUM_REGS-1:0]        wr_pulse,
    output logic [DATA_W-1:0]          cr_pulse
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_W - ADDR_LSB;

    localparam logic [0:0] B_IDLE = 1'b0;
    localparam logic [0:0] B_WAIT = 1'b1;

    logic                aw_full_q, aw_full_d;
    logic                w_full_q, w_full_d;
    logic                awready_q, awready_d;
    logic                wready_q, wready_d;
    logic [IDX_W-1:0]    aw_idx_q, aw_idx_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [STRB_W-1:0]   w_strb_q, w_strb_d;
    logic [0:0]          state_q, state_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic [DATA_W-1:0]   cr_pulse_q, cr_pulse_d;

    logic                aw_hs;
    logic                w_hs;
    logic                commit;
    logic                idx_hit;
    logic [31:0]         idx_ext;
    logic [DATA_W-1:0]   wmask;
    logic                unused_awaddr;

    assign unused_awaddr = ^{AWADDR[31:ADDR_W], AWADDR[ADDR_LSB-1:0]};

    always_comb begin
        aw_hs   = AWVALID && awready_q;
        w_hs    = WVALID && wready_q;
        commit  = aw_full_q && w_full_q && ((state_q == B_IDLE) || BREADY);
        idx_ext = 32'(aw_idx_q);
        idx_hit = idx_ext < 32'(NUM_REGS);

        wmask = '0;
        for (int b = 0; b < STRB_W; b++) begin
            wmask[b*8 +: 8] = {8{w_strb_q[b]}};
        end

        // Slots only accept while empty, so commit and a new handshake never coincide.
        aw_full_d = commit ? 1'b0 : (aw_hs ? 1'b1 : aw_full_q);
        w_full_d  = commit ? 1'b0 : (w_hs ? 1'b1 : w_full_q);
        awready_d = !aw_full_d;
        wready_d  = !w_full_d;
        aw_idx_d  = aw_hs ? AWADDR[ADDR_W-1:ADDR_LSB] : aw_idx_q;
        w_data_d  = w_hs ? WDATA : w_data_q;
        w_strb_d  = w_hs ? WSTRB : w_strb_q;

        state_d = state_q;
        bresp_d = bresp_q;
        if (commit) begin
            state_d = B_WAIT;
            bresp_d = idx_hit ? 2'b00 : 2'b10;
        end else if ((state_q == B_WAIT) && BREADY) begin
            state_d = B_IDLE;
        end

        regs_d     = regs_q;
        wr_pulse_d = '0;
        cr_pulse_d = '0;
        if (commit && idx_hit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (aw_idx_q == IDX_W'(i)) begin
                    regs_d[i]     = (regs_q[i] & ~wmask) | (w_data_q & wmask);
                    wr_pulse_d[i] = 1'b1;
                    if (i == 0) begin
                        cr_pulse_d = w_data_q & wmask & PULSE_MASK;
                    end
                end
            end
        end
        // Command bits are pulses only; they never hold state in register 0.
        regs_d[0] = regs_d[0] & ~PULSE_MASK;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            state_q    <= B_IDLE;
            bresp_q    <= 2'b00;
            wr_pulse_q <= '0;
            cr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            aw_idx_q   <= aw_idx_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            state_q    <= state_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            cr_pulse_q <= cr_pulse_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign AWREADY  = awready_q;
    assign WREADY   = wready_q;
    assign BVALID   = (state_q == B_WAIT);
    assign BRESP    = bresp_q;
    assign wr_pulse = wr_pulse_q;
    assign cr_pulse = cr_pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: tb/tb_axil_reg_write.sv
// Scoreboard bench for axil_reg_write: expectations queued at drive time, popped when the response appears.
module tb_axil_reg_write;

    localparam logic [31:0] PMASK = 32'h1;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [31:0]  awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [127:0] regs_o;
    logic [3:0]   wr_pulse;
    logic [31:0]  cr_pulse;

    always #5 aclk = ~aclk;

    axil_reg_write #(
        .DATA_W(32), .ADDR_W(8), .NUM_REGS(4), .PULSE_MASK(PMASK)
    ) dut (
        .ACLK(aclk), .ARESETN(aresetn),
        .AWADDR(awaddr), .AWVALID(awvalid), .AWREADY(awready),
        .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
        .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
        .regs(regs_o), .wr_pulse(wr_pulse), .cr_pulse(cr_pulse)
    );

    typedef struct {
        logic [1:0]  resp;
        int          idx;
        logic [31:0] val;
        logic [3:0]  pulse;
        logic [31:0] cr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [4];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] reg_at(input int i);
        return regs_o[i*32 +: 32];
    endfunction

    // Reference model: byte-lane merge, pulse bits of register 0 never stored.
    function automatic exp_t predict(input logic [31:0] addr, input logic [31:0] data,
                                     input logic [3:0] strb);
        exp_t        e;
        logic [31:0] m;
        logic [7:0]  a8;
        a8 = addr[7:0];
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{strb[b]}};
        e.idx   = int'(a8[7:2]);
        e.pulse = '0;
        e.cr    = '0;
        e.val   = '0;
        if (e.idx < 4) begin
            e.resp = 2'b00;
            e.pulse[e.idx] = 1'b1;
            mdl[e.idx] = (mdl[e.idx] & ~m) | (data & m);
            if (e.idx == 0) begin
                e.cr   = data & m & PMASK;
                mdl[0] = mdl[0] & ~PMASK;
            end
            e.val = mdl[e.idx];
        end else begin
            e.resp = 2'b10;
        end
        return e;
    endfunction

    task automatic put_aw(input logic [31:0] a);
        awaddr  = a;
        awvalid = 1'b1;
    endtask

    task automatic put_w(input logic [31:0] d, input logic [3:0] s);
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
    endtask

    task automatic wait_bvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bvalid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic setup_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        bit   ok;
        e = predict(a, d, s);
        put_aw(a);
        put_w(d, s);
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wait_bvalid(ok);
        if (!ok) begin
            $display("FAIL setup_write bvalid timeout addr=%h", a);
            $fatal(1);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0;
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        repeat (3) tick();
        n_total++; if (bvalid !== 1'b0) $display("FAIL reset_bvalid got %b want 0", bvalid); else n_pass++;
        n_total++; if (bresp !== 2'b00) $display("FAIL reset_bresp got %b want 00", bresp); else n_pass++;
        n_total++; if (regs_o !== 128'h0) $display("FAIL reset_regs got %h want 0", regs_o); else n_pass++;
        n_total++; if ({wr_pulse, cr_pulse} !== 36'h0) $display("FAIL reset_pulses got %h/%h want 0", wr_pulse, cr_pulse); else n_pass++;
        aresetn = 1'b1;
        tick();
        n_total++; if ({awready, wready} !== 2'b11) $display("FAIL reset_ready got %b want 11", {awready, wready}); else n_pass++;
    endtask

    task automatic test_same_cycle();
        exp_t e;
        sb.push_back(predict(32'h04, 32'hDEADBEEF, 4'hF));
        put_aw(32'h04);
        put_w(32'hDEADBEEF, 4'hF);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        n_total++; if ({bvalid, awready, wready} !== 3'b000) $display("FAIL same_accept got %b want 000", {bvalid, awready, wready}); else n_pass++;
        tick();
        n_total++; if (bvalid !== 1'b1) $display("FAIL same_bvalid got %b want 1", bvalid); else n_pass++;
        e = sb.pop_front();
        n_total++; if (bresp !== e.resp) $display("FAIL same_bresp got %b want %b", bresp, e.resp); else n_pass++;
        n_total++; if (reg_at(1) !== 32'hDEADBEEF) $display("FAIL same_reg1 got %h want deadbeef", reg_at(1)); else n_pass++;
        n_total++; if (wr_pulse !== e.pulse) $display("FAIL same_wr_pulse got %b want %b", wr_pulse, e.pulse); else n_pass++;
        tick();
        n_total++; if ({bvalid, wr_pulse} !== 5'b10000) $display("FAIL same_hold got %b want 10000", {bvalid, wr_pulse}); else n_pass++;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        n_total++; if (bvalid !== 1'b0) $display("FAIL same_bdone got %b want 0", bvalid); else n_pass++;
    endtask

    task automatic test_w_first();
        exp_t e;
        bit   ok;
        setup_write(32'h08, 32'hAAAAAAAA, 4'hF);
        sb.push_back(predict(32'h08, 32'h11223344, 4'b0101));
        put_w(32'h11223344, 4'b0101);
        tick();
        wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_total++; if ({awready, wready, bvalid} !== 3'b100) $display("FAIL wfirst_wait%0d got %b want 100", c, {awready, wready, bvalid}); else n_pass++;
            tick();
        end
        put_aw(32'h08);
        tick();
        awvalid = 1'b0;
        wait_bvalid(ok);
        n_total++; if (!ok) $display("FAIL wfirst_timeout got 0 want bvalid"); else n_pass++;
        e = sb.pop_front();
        n_total++; if (bresp !== e.resp) $display("FAIL wfirst_bresp got %b want %b", bresp, e.resp); else n_pass++;
        n_total++; if (reg_at(2) !== 32'hAA22AA44) $display("FAIL wfirst_reg2 got %h want aa22aa44", reg_at(2)); else n_pass++;
        n_total++; if (wr_pulse !== e.pulse) $display("FAIL wfirst_wr_pulse got %b want %b", wr_pulse, e.pulse); else n_pass++;
        bready = 1'b1; tick(); bready = 1'b0;
    endtask

    task automatic test_pulse();
        exp_t e;
        bit   ok;
        sb.push_back(predict(32'h00, 32'h3, 4'hF));
        put_aw(32'h00);
        put_w(32'h3, 4'hF);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        wait_bvalid(ok);
        n_total++; if (!ok) $display("FAIL pulse_timeout got 0 want bvalid"); else n_pass++;
        e = sb.pop_front();
        n_total++; if (cr_pulse !== e.cr) $display("FAIL pulse_cr got %h want %h", cr_pulse, e.cr); else n_pass++;
        n_total++; if (reg_at(0) !== 32'h2) $display("FAIL pulse_reg0 got %h want 2", reg_at(0)); else n_pass++;
        n_total++; if (wr_pulse !== e.pulse) $display("FAIL pulse_wr_pulse got %b want %b", wr_pulse, e.pulse); else n_pass++;
        tick();
        n_total++; if (cr_pulse !== 32'h0) $display("FAIL pulse_cr_clear got %h want 0", cr_pulse); else n_pass++;
        bready = 1'b1; tick(); bready = 1'b0;
    endtask

    task automatic test_unmapped();
        exp_t e;
        bit   ok;
        sb.push_back(predict(32'h10, 32'hFFFFFFFF, 4'hF));
        put_aw(32'h10);
        put_w(32'hFFFFFFFF, 4'hF);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        wait_bvalid(ok);
        n_total++; if (!ok) $display("FAIL unmapped_timeout got 0 want bvalid"); else n_pass++;
        e = sb.pop_front();
        n_total++; if (bresp !== 2'b10) $display("FAIL unmapped_bresp got %b want 10", bresp); else n_pass++;
        n_total++; if ({wr_pulse, cr_pulse} !== {e.pulse, e.cr}) $display("FAIL unmapped_pulses got %b/%h want 0", wr_pulse, cr_pulse); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (reg_at(i) !== mdl[i]) $display("FAIL unmapped_reg%0d got %h want %h", i, reg_at(i), mdl[i]); else n_pass++;
        end
        bready = 1'b1; tick(); bready = 1'b0;
    endtask

    task automatic test_strb_edges();
        logic [31:0] ta [3] = '{32'h0C, 32'h0E, 32'h104};
        logic [31:0] td [3] = '{32'hFFFFFFFF, 32'h55AA55AA, 32'h0000BEEF};
        logic [3:0]  ts [3] = '{4'h0, 4'hF, 4'h3};
        exp_t        e;
        bit          ok;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(predict(ta[k], td[k], ts[k]));
            put_aw(ta[k]);
            put_w(td[k], ts[k]);
            tick();
            awvalid = 1'b0; wvalid = 1'b0;
            wait_bvalid(ok);
            n_total++; if (!ok) $display("FAIL strb%0d_timeout got 0 want bvalid", k); else n_pass++;
            e = sb.pop_front();
            n_total++; if ({bresp, wr_pulse} !== {e.resp, e.pulse}) $display("FAIL strb%0d_resp got %b/%b want %b/%b", k, bresp, wr_pulse, e.resp, e.pulse); else n_pass++;
            n_total++; if (reg_at(e.idx) !== e.val) $display("FAIL strb%0d_reg got %h want %h", k, reg_at(e.idx), e.val); else n_pass++;
            bready = 1'b1; tick(); bready = 1'b0;
        end
    endtask

    task automatic test_bready_hold();
        exp_t        e1;
        exp_t        e2;
        logic [31:0] old2;
        bit          ok;
        sb.push_back(predict(32'h14, 32'hCAFEF00D, 4'hF));
        put_aw(32'h14);
        put_w(32'hCAFEF00D, 4'hF);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        wait_bvalid(ok);
        n_total++; if (!ok) $display("FAIL hold_timeout got 0 want bvalid"); else n_pass++;
        old2 = mdl[2];
        sb.push_back(predict(32'h08, 32'h02020202, 4'hF));
        e1 = sb[0];
        put_aw(32'h08);
        put_w(32'h02020202, 4'hF);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_total++; if ({bvalid, bresp, awready, wready} !== {1'b1, e1.resp, 2'b00}) $display("FAIL hold_c%0d got %b want %b", c, {bvalid, bresp, awready, wready}, {1'b1, e1.resp, 2'b00}); else n_pass++;
            n_total++; if (reg_at(2) !== old2) $display("FAIL hold_reg2_c%0d got %h want %h", c, reg_at(2), old2); else n_pass++;
            tick();
        end
        bready = 1'b1;
        tick();
        void'(sb.pop_front());
        e2 = sb.pop_front();
        n_total++; if ({bvalid, bresp} !== {1'b1, e2.resp}) $display("FAIL hold_second_b got %b want %b", {bvalid, bresp}, {1'b1, e2.resp}); else n_pass++;
        n_total++; if (reg_at(2) !== e2.val) $display("FAIL hold_second_reg2 got %h want %h", reg_at(2), e2.val); else n_pass++;
        n_total++; if (wr_pulse !== e2.pulse) $display("FAIL hold_second_wr_pulse got %b want %b", wr_pulse, e2.pulse); else n_pass++;
        tick();
        bready = 1'b0;
        n_total++; if (bvalid !== 1'b0) $display("FAIL hold_bdone got %b want 0", bvalid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [4] = '{32'h04, 32'h08, 32'h0C, 32'h04};
        logic [31:0] td [4] = '{32'h01234567, 32'h89ABCDEF, 32'h0BADCAFE, 32'h76543210};
        exp_t        e;
        bit          hs;
        int          k = 0;
        int          commits = 0;
        bready = 1'b1;
        sb.push_back(predict(ta[0], td[0], 4'hF));
        put_aw(ta[0]);
        put_w(td[0], 4'hF);
        for (int cyc = 0; cyc < 8; cyc++) begin
            hs = awvalid && awready && wready;
            tick();
            if (wr_pulse !== 4'h0) begin
                commits++;
                e = sb.pop_front();
                n_total++; if ({bvalid, bresp, wr_pulse} !== {1'b1, e.resp, e.pulse}) $display("FAIL b2b_resp%0d got %b want %b", commits, {bvalid, bresp, wr_pulse}, {1'b1, e.resp, e.pulse}); else n_pass++;
                n_total++; if (reg_at(e.idx) !== e.val) $display("FAIL b2b_reg%0d got %h want %h", commits, reg_at(e.idx), e.val); else n_pass++;
            end
            if (hs) begin
                k++;
                if (k < 4) begin
                    sb.push_back(predict(ta[k], td[k], 4'hF));
                    put_aw(ta[k]);
                    put_w(td[k], 4'hF);
                end else begin
                    awvalid = 1'b0; wvalid = 1'b0;
                end
            end
        end
        n_total++; if (commits !== 4) $display("FAIL b2b_rate got %0d commits want 4 in 8 cycles", commits); else n_pass++;
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        bready = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   ok;
        sb.push_back(predict(32'h04, 32'h0F0F0F0F, 4'hF));
        put_aw(32'h04);
        put_w(32'h0F0F0F0F, 4'hF);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        wait_bvalid(ok);
        n_total++; if (!ok) $display("FAIL rmid_timeout got 0 want bvalid"); else n_pass++;
        void'(sb.pop_front());
        put_w(32'h99999999, 4'hF);
        tick();
        wvalid = 1'b0;
        n_total++; if (wready !== 1'b0) $display("FAIL rmid_w_held got %b want 0", wready); else n_pass++;
        aresetn = 1'b0;
        #1;
        n_total++; if ({bvalid, wr_pulse} !== 5'b00000) $display("FAIL rmid_async_b got %b want 00000", {bvalid, wr_pulse}); else n_pass++;
        n_total++; if (regs_o !== 128'h0) $display("FAIL rmid_async_regs got %h want 0", regs_o); else n_pass++;
        for (int i = 0; i < 4; i++) mdl[i] = '0;
        sb.delete();
        tick();
        aresetn = 1'b1;
        tick();
        n_total++; if ({awready, wready} !== 2'b11) $display("FAIL rmid_ready got %b want 11", {awready, wready}); else n_pass++;
        sb.push_back(predict(32'h08, 32'h12345678, 4'hF));
        put_aw(32'h08);
        tick();
        awvalid = 1'b0;
        tick();
        n_total++; if ({bvalid, awready, wready} !== 3'b001) $display("FAIL rmid_w_dropped got %b want 001", {bvalid, awready, wready}); else n_pass++;
        put_w(32'h12345678, 4'hF);
        tick();
        wvalid = 1'b0;
        wait_bvalid(ok);
        n_total++; if (!ok) $display("FAIL rmid_next_timeout got 0 want bvalid"); else n_pass++;
        e = sb.pop_front();
        n_total++; if ({bresp, wr_pulse} !== {e.resp, e.pulse}) $display("FAIL rmid_next_resp got %b/%b want %b/%b", bresp, wr_pulse, e.resp, e.pulse); else n_pass++;
        n_total++; if (reg_at(2) !== 32'h12345678) $display("FAIL rmid_next_reg2 got %h want 12345678", reg_at(2)); else n_pass++;
        bready = 1'b1; tick(); bready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_same_cycle();
        test_w_first();
        test_pulse();
        test_unmapped();
        test_strb_edges();
        test_bready_hold();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
